// File: rtl/instrumented_adder_sklansky_wrapped_pkg.sv
// Shared constants for the instrumented Sklansky adder wrapper.
// Latency: n/a (constants only).
// Backpressure: n/a.
package instrumented_adder_sklansky_wrapped_pkg;

  // Datapath and pad geometry
  localparam int WIDTH     = 32;
  localparam int LEVELS    = 5;   // log2(WIDTH) prefix levels
  localparam int IO_W      = 38;
  localparam int EXT_PIN   = 8;
  localparam int CHAIN_PIN = 9;
  localparam int CARRY_PIN = 10;

  // LA3 command strobe bit positions
  localparam int CMD_LOAD_A    = 0;
  localparam int CMD_LOAD_B    = 1;
  localparam int CMD_RING_MASK = 2;
  localparam int CMD_EXT_MASK  = 3;
  localparam int CMD_SUM_MASK  = 4;
  localparam int CMD_RUN       = 5;
  localparam int CMD_CLEAR     = 6;
  localparam int CMD_W         = 7;

  // Only the chain and carry pads are driven while the project is selected
  localparam logic [IO_W-1:0] OEB_ACTIVE =
    ~((IO_W'(1) << CHAIN_PIN) | (IO_W'(1) << CARRY_PIN));

endpackage

// File: rtl/instrumented_adder_sklansky_wrapped_if.sv
// GPIO and logic-analyser bundle between the SoC side and the adder wrapper.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level-sampled every clock.
interface instrumented_adder_sklansky_wrapped_if;
  import instrumented_adder_sklansky_wrapped_pkg::*;

  logic [IO_W-1:0]  io_in;
  logic [IO_W-1:0]  io_out;
  logic [IO_W-1:0]  io_oeb;
  logic [WIDTH-1:0] la1_data_in;
  logic [WIDTH-1:0] la1_data_out;
  logic [WIDTH-1:0] la1_oenb;
  logic [WIDTH-1:0] la2_data_in;
  logic [WIDTH-1:0] la2_data_out;
  logic [WIDTH-1:0] la2_oenb;
  logic [WIDTH-1:0] la3_data_in;
  logic [WIDTH-1:0] la3_data_out;
  logic [WIDTH-1:0] la3_oenb;

  // SoC / harness side
  modport master (
    output io_in, la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb,
    input  io_out, io_oeb, la1_data_out, la2_data_out, la3_data_out
  );

  // User-project side
  modport slave (
    input  io_in, la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb,
    output io_out, io_oeb, la1_data_out, la2_data_out, la3_data_out
  );

endinterface

// File: rtl/instrumented_adder_sklansky_wrapped_sklansky_adder32.sv
// 32-bit Sklansky parallel-prefix adder, carry-in tied to zero.
// Latency: purely combinational, five black-cell levels.
// Backpressure: none.
module instrumented_adder_sklansky_wrapped_sklansky_adder32
  import instrumented_adder_sklansky_wrapped_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // w_g[l][i] / w_p[l][i]: group generate/propagate of bit i after l levels
  logic [WIDTH-1:0] w_g [0:LEVELS];
  logic [WIDTH-1:0] w_p [0:LEVELS];
  logic             w_unused_p;

  assign w_g[0] = i_a & i_b;
  assign w_p[0] = i_a ^ i_b;

  // At level l, bits in the upper half of each 2^(l+1) block absorb the
  // group ending at the last bit of the lower half (Sklansky fan-out).
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_black
        localparam int J = ((i >> l) << l) - 1;
        assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][J]);
        assign w_p[l+1][i] = w_p[l][i] & w_p[l][J];
      end else begin : g_pass
        assign w_g[l+1][i] = w_g[l][i];
        assign w_p[l+1][i] = w_p[l][i];
      end
    end
  end

  // After the last level w_g[LEVELS][i] is the carry into bit i+1
  assign o_sum      = w_p[0] ^ {w_g[LEVELS][WIDTH-2:0], 1'b0};
  assign o_cout     = w_g[LEVELS][WIDTH-1];
  assign w_unused_p = ^w_p[LEVELS];

endmodule

// File: rtl/instrumented_adder_sklansky_wrapped.sv
// Caravel wrapper: LA-loaded operands/masks, Sklansky adder with a ring-loop toggle counter.
// Latency: sum/carry combinational from registers; commands take effect on the next edge.
// Backpressure: none; 'active' low parks outputs and freezes all state.
module instrumented_adder_sklansky_wrapped
  import instrumented_adder_sklansky_wrapped_pkg::*;
(
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic active,
  instrumented_adder_sklansky_wrapped_if.slave bus
);

  logic [WIDTH-1:0] r_a_input, r_b_input, r_ring_mask, r_ext_mask, r_sum_mask;
  logic [WIDTH-1:0] r_count;
  logic             r_chain_out;

  logic [WIDTH-1:0] w_la1_eff, w_la2_eff, w_a_eff, w_sum;
  logic [CMD_W-1:0] w_cmd;
  logic             w_ext_bit, w_carry, w_fb, w_unused;

  // SoC-driven LA bits only count where the SoC actually owns the line
  assign w_la1_eff = bus.la1_data_in & ~bus.la1_oenb;
  assign w_la2_eff = bus.la2_data_in & ~bus.la2_oenb;
  assign w_cmd     = bus.la3_data_in[CMD_W-1:0] & ~bus.la3_oenb[CMD_W-1:0];
  assign w_ext_bit = bus.io_in[EXT_PIN];

  // Ring bits beat external bits, which beat the loaded operand
  assign w_a_eff = (r_ring_mask & {WIDTH{r_chain_out}})
                 | (~r_ring_mask & r_ext_mask & {WIDTH{w_ext_bit}})
                 | (~r_ring_mask & ~r_ext_mask & r_a_input);

  instrumented_adder_sklansky_wrapped_sklansky_adder32 u_adder (
    .i_a    (w_a_eff),
    .i_b    (r_b_input),
    .o_sum  (w_sum),
    .o_cout (w_carry)
  );

  // Inverting parity of the watched sum bits; an empty mask yields a constant 1
  assign w_fb = ~^(w_sum & r_sum_mask);

  assign w_unused = ^{bus.io_in[IO_W-1:EXT_PIN+1], bus.io_in[EXT_PIN-1:0],
                      bus.la3_data_in[WIDTH-1:CMD_W], bus.la3_oenb[WIDTH-1:CMD_W]};

  // Operand and mask loads from LA strobes
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_a_input   <= '0;
      r_b_input   <= '0;
      r_ring_mask <= '0;
      r_ext_mask  <= '0;
      r_sum_mask  <= '0;
    end else if (active) begin
      if (w_cmd[CMD_LOAD_A])    r_a_input   <= w_la1_eff;
      if (w_cmd[CMD_LOAD_B])    r_b_input   <= w_la2_eff;
      if (w_cmd[CMD_RING_MASK]) r_ring_mask <= w_la1_eff;
      if (w_cmd[CMD_EXT_MASK])  r_ext_mask  <= w_la1_eff;
      if (w_cmd[CMD_SUM_MASK])  r_sum_mask  <= w_la2_eff;
    end
  end

  // Ring loop register and toggle counter; clear wins over a same-cycle toggle
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_chain_out <= 1'b0;
      r_count     <= '0;
    end else if (active) begin
      if (w_cmd[CMD_RUN]) r_chain_out <= w_fb;
      if (w_cmd[CMD_CLEAR])
        r_count <= '0;
      else if (w_cmd[CMD_RUN] && (w_fb != r_chain_out))
        r_count <= r_count + WIDTH'(1);
    end
  end

  // Output gating: everything parked and tri-stated when not selected
  always_comb begin
    bus.io_out       = '0;
    bus.io_oeb       = '1;
    bus.la1_data_out = '0;
    bus.la2_data_out = '0;
    bus.la3_data_out = '0;
    if (active) begin
      bus.io_out[CHAIN_PIN] = r_chain_out;
      bus.io_out[CARRY_PIN] = w_carry;
      bus.io_oeb            = OEB_ACTIVE;
      bus.la1_data_out      = r_count;
      bus.la2_data_out      = w_sum;
      bus.la3_data_out      = {{(WIDTH-2){1'b0}}, w_carry, r_chain_out};
    end
  end

endmodule

// File: tb/tb_instrumented_adder_sklansky_wrapped.sv
// Directed bench with a scoreboard queue and a negedge monitor.
module tb_instrumented_adder_sklansky_wrapped;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic active = 1'b0;

  always #5 clk = ~clk;

  instrumented_adder_sklansky_wrapped_if bus ();

  instrumented_adder_sklansky_wrapped dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .active   (active),
    .bus      (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] la1;
    logic [31:0] la2;
    logic [31:0] la3;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
  } exp_t;

  localparam logic [37:0] OEB_ON  = 38'h3F_FFFF_F9FF;
  localparam logic [37:0] OEB_OFF = 38'h3F_FFFF_FFFF;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Monitor: compares every queued expectation at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin : pop_one
        exp_t e;
        e = q.pop_front();
        chk({e.name, ".la1"},    {6'b0, bus.la1_data_out}, {6'b0, e.la1});
        chk({e.name, ".la2"},    {6'b0, bus.la2_data_out}, {6'b0, e.la2});
        chk({e.name, ".la3"},    {6'b0, bus.la3_data_out}, {6'b0, e.la3});
        chk({e.name, ".io_out"}, bus.io_out, e.io_out);
        chk({e.name, ".io_oeb"}, bus.io_oeb, e.io_oeb);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wait(input exp_t e);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic expect_on(input string nm, input logic [31:0] cnt, input logic [31:0] sum,
                           input logic carry, input logic chain);
    exp_t e;
    e.name       = nm;
    e.la1        = cnt;
    e.la2        = sum;
    e.la3        = {30'b0, carry, chain};
    e.io_out     = '0;
    e.io_out[9]  = chain;
    e.io_out[10] = carry;
    e.io_oeb     = OEB_ON;
    push_wait(e);
  endtask

  task automatic expect_off(input string nm);
    exp_t e;
    e.name   = nm;
    e.la1    = '0;
    e.la2    = '0;
    e.la3    = '0;
    e.io_out = '0;
    e.io_oeb = OEB_OFF;
    push_wait(e);
  endtask

  // One-cycle command strobe with LA1/LA2 data
  task automatic cmd(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.la1_data_in = a;
    bus.la2_data_in = b;
    bus.la3_data_in = c;
    tick(1);
    bus.la3_data_in = '0;
  endtask

  initial begin
    bus.io_in       = '0;
    bus.la1_data_in = '0;
    bus.la2_data_in = '0;
    bus.la3_data_in = '0;
    bus.la1_oenb    = '0;
    bus.la2_oenb    = '0;
    bus.la3_oenb    = '0;
    active          = 1'b1;
    #2;
    expect_on("reset", 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1);

    // Plain add and wrap-around
    cmd(32'h03, 32'd5, 32'd7);
    expect_on("add", 32'd0, 32'd12, 1'b0, 1'b0);
    cmd(32'h03, 32'hFFFF_FFFF, 32'd1);
    expect_on("wrap", 32'd0, 32'd0, 1'b1, 1'b0);

    // oenb masking of LA inputs
    bus.la1_oenb = '1;
    cmd(32'h01, 32'h0000_1234, 32'd0);
    bus.la1_oenb = '0;
    expect_on("oenb_a", 32'd0, 32'd1, 1'b0, 1'b0);
    bus.la3_oenb = '1;
    cmd(32'h03, 32'd9, 32'd9);
    bus.la3_oenb = '0;
    expect_on("oenb_cmd", 32'd0, 32'd1, 1'b0, 1'b0);

    // Ring through bit 0
    cmd(32'h03, 32'd0, 32'd0);
    cmd(32'h14, 32'd1, 32'd1);
    expect_on("ring_idle", 32'd0, 32'd0, 1'b0, 1'b0);
    bus.la3_data_in = 32'h20;
    tick(5);
    expect_on("ring5", 32'd5, 32'd1, 1'b0, 1'b1);
    tick(5);
    expect_on("ring10", 32'd10, 32'd0, 1'b0, 1'b0);
    bus.la3_data_in = '0;
    cmd(32'h40, 32'd0, 32'd0);
    expect_on("clear", 32'd0, 32'd0, 1'b0, 1'b0);

    // Ring through bit 20 directly
    cmd(32'h04, 32'h0010_0000, 32'd0);
    cmd(32'h10, 32'd0, 32'h0010_0000);
    expect_on("c20_idle", 32'd0, 32'd0, 1'b0, 1'b0);
    bus.la3_data_in = 32'h20;
    tick(3);
    expect_on("c20_run3", 32'd3, 32'h0010_0000, 1'b0, 1'b1);
    tick(1);
    expect_on("c20_run4", 32'd4, 32'd0, 1'b0, 1'b0);
    bus.la3_data_in = '0;

    // Ring via bit 0 rippling up the carry chain into bit 20
    cmd(32'h06, 32'd1, 32'h000F_FFFF);
    expect_on("c0_idle", 32'd4, 32'h000F_FFFF, 1'b0, 1'b0);
    bus.la3_data_in = 32'h20;
    tick(3);
    expect_on("c0_run3", 32'd7, 32'h0010_0000, 1'b0, 1'b1);
    bus.la3_data_in = '0;

    // Gating: strobes ignored and outputs parked while inactive
    active = 1'b0;
    bus.la1_data_in = 32'h0000_AAAA;
    bus.la3_data_in = 32'h61;
    tick(2);
    bus.la3_data_in = '0;
    expect_off("gated");
    active = 1'b1;
    expect_on("ungated", 32'd7, 32'h0010_0000, 1'b0, 1'b1);

    // External pin source, with ring keeping priority on bit 0
    bus.io_in[8] = 1'b1;
    cmd(32'h08, 32'd3, 32'd0);
    expect_on("ext_hi", 32'd7, 32'h0010_0002, 1'b0, 1'b1);
    bus.io_in[8] = 1'b0;
    tick(1);
    expect_on("ext_lo", 32'd7, 32'h0010_0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run
    bus.la3_data_in = 32'h20;
    tick(2);
    rst_n = 1'b0;
    expect_on("reset_mid", 32'd0, 32'd0, 1'b0, 1'b0);
    bus.la3_data_in = '0;
    rst_n = 1'b1;
    tick(2);
    expect_on("post_reset", 32'd0, 32'd0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
